mul_share_arb: RTL and testbench

Round-robin scheduler that shares one 5x5 unsigned multiplier core (10-bit product, fixed pipeline latency, no backpressure) among N requesters. It accepts at most one operand pair per cycle and registers the operands into the core. A tag pipeline tracks which requester issued each operation, and the block returns each product to that requester as a one-cycle response pulse. It sits between the client blocks and the multiplier core instance.

---
 rtl/mul_share_arb_if.sv | 39 +++
 rtl/mul_share_arb.sv | 165 ++++++++++++++++
 tb/tb_mul_share_arb.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// Client-side bundle for the shared-multiplier arbiter. It carries the issue
// handshake (enable, per-requester valid/operands, one-hot grant) and the
// response path (one-hot strobe, product, busy).
interface mul_share_arb_if #(
    parameter int N_REQ = 4
);
    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [5*N_REQ-1:0]   req_a;
    logic [5*N_REQ-1:0]   req_b;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     rsp_valid;
    logic [9:0]           rsp_p;
    logic                 busy;

    // Client side: drives requests, sinks grants and responses
    modport master (
        output en,
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  rsp_valid,
        input  rsp_p,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  en,
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output rsp_valid,
        output rsp_p,
        output busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one 5x5 unsigned multiplier core among N_REQ
// requesters. One operand pair is accepted per cycle and registered into the
// core; a tag shift register of depth MUL_LAT+1 remembers who issued each op
// so the product can be returned as a one-cycle, one-hot response pulse.
// The core has no backpressure, so responses cannot be stalled either.
module mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_share_arb_if.slave bus,
    output logic [4:0]  mul_a,
    output logic [4:0]  mul_b,
    input  logic [9:0]  mul_p
);

    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = MUL_LAT + 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    // Registered state
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [4:0]       mul_a_q,     mul_a_d;
    logic [4:0]       mul_b_q,     mul_b_d;
    logic [DEPTH-1:0] tag_vld_q,   tag_vld_d;
    logic [IDW-1:0]   tag_id_q [DEPTH];
    logic [IDW-1:0]   tag_id_d [DEPTH];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [9:0]       rsp_p_q,     rsp_p_d;

    // Arbitration / datapath combinational signals
    logic             found_s;
    logic [IDW-1:0]   gnt_idx_s;
    logic [IDW:0]     cand_s;
    logic [N_REQ-1:0] ready_s;
    logic             accept_s;
    logic [4:0]       sel_a_s;
    logic [4:0]       sel_b_s;

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            cand_s = {1'b0, ptr_q} + (IDW+1)'(j);
            if (cand_s >= (IDW+1)'(N_REQ)) begin
                cand_s = cand_s - (IDW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && bus.req_valid[cand_s[IDW-1:0]]) begin
                found_s   = 1'b1;
                gnt_idx_s = cand_s[IDW-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot grant; suppressed while disabled or held in reset
    always_comb begin
        ready_s = '0;
        if (rst_n && bus.en && found_s) begin
            ready_s = ONE_HOT0 << gnt_idx_s;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s      = |(bus.req_valid & ready_s);
    assign bus.req_ready = ready_s;

    // Operand mux selecting the granted requester's packed operands
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx_s == IDW'(i)) begin
                sel_a_s = bus.req_a[5*i +: 5];
                sel_b_s = bus.req_b[5*i +: 5];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Next-state: pointer advance, operand load, tag shift and response capture
    always_comb begin
        ptr_d       = ptr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_vld_d   = '0;
        rsp_valid_d = '0;
        rsp_p_d     = rsp_p_q;
        for (int i = 0; i < DEPTH; i++) begin
            tag_id_d[i] = '0;
        end

        if (accept_s) begin
            if (gnt_idx_s == IDW'(N_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + IDW'(1);
            end
            mul_a_d = sel_a_s;
            mul_b_d = sel_b_s;
        end else begin
            ptr_d   = ptr_q;
            mul_a_d = mul_a_q;
            mul_b_d = mul_b_q;
        end

        // Stage 0 records the issuer; later stages follow the core latency
        tag_vld_d[0] = accept_s;
        tag_id_d[0]  = gnt_idx_s;
        for (int i = 1; i < DEPTH; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        // The core product is valid exactly when the op reaches the last stage
        if (tag_vld_q[DEPTH-1]) begin
            rsp_valid_d = ONE_HOT0 << tag_id_q[DEPTH-1];
            rsp_p_d     = mul_p;
        end else begin
            rsp_valid_d = '0;
            rsp_p_d     = rsp_p_q;
        end
    end

    // State registers; reset discards every in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            mul_a_q     <= 5'd0;
            mul_b_q     <= 5'd0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= 10'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.busy      = |tag_vld_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: table-driven grant vectors, a
// scoreboard that predicts every response (id, product, arrival cycle), and
// hand-written single-op / reset-in-flight sequences. Includes a 3-cycle
// behavioural multiplier core.
module tb_mul_share_arb;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 3;
    localparam int LAT     = MUL_LAT + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mul_share_arb_if #(.N_REQ(N_REQ)) bus();

    logic [4:0] mul_a;
    logic [4:0] mul_b;
    logic [9:0] mul_p;
    logic [9:0] p0, p1, p2;

    // Multiplier core model: product valid MUL_LAT cycles after operand change
    always @(posedge clk) begin
        p0 <= {5'd0, mul_a} * {5'd0, mul_b};
        p1 <= p0;
        p2 <= p1;
    end
    assign mul_p = p2;

    mul_share_arb #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] id;
        logic [9:0] p;
        int         due;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  vld;
        logic [19:0] a;
        logic [19:0] b;
        logic [3:0]  rdy;
    } vec_t;

    exp_t sbq[$];
    exp_t e;
    vec_t tbl_main[$];
    vec_t tbl_pre[$];
    vec_t tbl_post[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [19:0] pk(int x3, int x2, int x1, int x0);
        return {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
    endfunction

    function automatic vec_t mk(logic en, logic [3:0] vld, logic [19:0] a,
                                logic [19:0] b, logic [3:0] rdy);
        vec_t v;
        v.en = en; v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Predict a response for the expected grant of vector v
    task automatic push_exp(vec_t v);
        exp_t x;
        logic [4:0] ax, bx;
        for (int i = 0; i < N_REQ; i++) begin
            if (v.rdy[i]) begin
                ax    = v.a[5*i +: 5];
                bx    = v.b[5*i +: 5];
                x.id  = v.rdy;
                x.p   = {5'd0, ax} * {5'd0, bx};
                x.due = cyc + LAT;
                sbq.push_back(x);
            end
        end
    endtask

    task automatic apply(vec_t v, string name);
        @(negedge clk);
        bus.en        = v.en;
        bus.req_valid = v.vld;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        #1;
        chk(name, 32'(bus.req_ready), 32'(v.rdy));
        if (v.rdy != 4'b0000) push_exp(v);
    endtask

    // Response monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.rsp_valid !== 4'b0000) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b rsp_p=%0d cycle=%0d, none expected",
                         bus.rsp_valid, bus.rsp_p, cyc);
            end else begin
                e = sbq.pop_front();
                if (bus.rsp_valid !== e.id || bus.rsp_p !== e.p || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp: got id=%b p=%0d cycle=%0d expected id=%b p=%0d cycle=%0d",
                             bus.rsp_valid, bus.rsp_p, cyc, e.id, e.p, e.due);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: got none expected id=%b p=%0d at cycle=%0d",
                     sbq[0].id, sbq[0].p, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    initial begin
        vec_t idle;
        logic [19:0] ca, cb, fa, fb, ga, gb;
        idle = mk(1'b1, 4'b0000, 20'd0, 20'd0, 4'b0000);
        ca = pk(4, 3, 2, 1);   cb = pk(2, 2, 2, 2);
        fa = pk(0, 6, 0, 9);   fb = pk(0, 7, 0, 3);
        ga = pk(8, 7, 6, 5);   gb = pk(1, 2, 3, 4);

        // Boundary operands, then a lone grant to 3 so ptr wraps to 0
        tbl_main.push_back(mk(1'b1, 4'b0100, pk(0, 31, 0, 0), pk(0, 31, 0, 0), 4'b0100));
        tbl_main.push_back(mk(1'b1, 4'b0010, pk(0, 0, 0, 0),  pk(0, 0, 31, 0), 4'b0010));
        tbl_main.push_back(mk(1'b1, 4'b1000, pk(5, 0, 0, 0),  pk(5, 0, 0, 0),  4'b1000));
        // Contention: all valid, ungranted ones hold
        tbl_main.push_back(mk(1'b1, 4'b1111, ca, cb, 4'b0001));
        tbl_main.push_back(mk(1'b1, 4'b1110, ca, cb, 4'b0010));
        tbl_main.push_back(mk(1'b1, 4'b1100, ca, cb, 4'b0100));
        tbl_main.push_back(mk(1'b1, 4'b1000, ca, cb, 4'b1000));
        // Fairness between 0 and 2
        for (int i = 0; i < 5; i++)
            tbl_main.push_back(mk(1'b1, 4'b0101, fa, fb, (i % 2 == 0) ? 4'b0001 : 4'b0100));
        // Grant to 3, then search restarts at 0
        tbl_main.push_back(mk(1'b1, 4'b1001, pk(11, 0, 0, 9), pk(13, 0, 0, 3), 4'b1000));
        tbl_main.push_back(mk(1'b1, 4'b0001, pk(0, 0, 0, 9),  pk(0, 0, 0, 3),  4'b0001));
        // Enable gating while earlier ops drain, then resume at ptr=1
        for (int i = 0; i < 6; i++)
            tbl_main.push_back(mk(1'b0, 4'b1111, ga, gb, 4'b0000));
        tbl_main.push_back(mk(1'b1, 4'b1111, ga, gb, 4'b0010));
        tbl_main.push_back(mk(1'b1, 4'b1101, ga, gb, 4'b0100));
        tbl_main.push_back(mk(1'b1, 4'b1001, ga, gb, 4'b1000));
        tbl_main.push_back(mk(1'b1, 4'b0001, ga, gb, 4'b0001));
        for (int i = 0; i < 7; i++) tbl_main.push_back(idle);
        // Three ops in flight right before reset, leaving ptr=1
        tbl_pre.push_back(mk(1'b1, 4'b0010, pk(0, 0, 9, 0),  pk(0, 0, 9, 0),  4'b0010));
        tbl_pre.push_back(mk(1'b1, 4'b0100, pk(0, 10, 0, 0), pk(0, 10, 0, 0), 4'b0100));
        tbl_pre.push_back(mk(1'b1, 4'b0001, pk(0, 0, 0, 12), pk(0, 0, 0, 12), 4'b0001));
        // After reset the search must start at 0 again
        tbl_post.push_back(mk(1'b1, 4'b1111, pk(31, 30, 29, 28), pk(1, 1, 1, 31), 4'b0001));
        tbl_post.push_back(mk(1'b1, 4'b1110, pk(31, 30, 29, 28), pk(1, 1, 1, 31), 4'b0010));
        for (int i = 0; i < 8; i++) tbl_post.push_back(idle);

        // Power-up reset with requests present: no grant, outputs cleared
        bus.en = 1'b1; bus.req_valid = 4'b1111; bus.req_a = ga; bus.req_b = gb;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_mul_a", 32'(mul_a), 32'd0);
        chk("reset_mul_b", 32'(mul_b), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_p", 32'(bus.rsp_p), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 4'b0000;
        @(negedge clk) rst_n = 1'b1;

        // Single op: 3*7 to requester 0, busy for exactly four cycles
        apply(mk(1'b1, 4'b0001, pk(0, 0, 0, 3), pk(0, 0, 0, 7), 4'b0001), "single_ready");
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        chk("single_mul_a", 32'(mul_a), 32'd3);
        chk("single_mul_b", 32'(mul_b), 32'd7);
        chk("single_busy1", 32'(bus.busy), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("single_busy%0d", i), 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        chk("single_busy_off", 32'(bus.busy), 32'd0);

        foreach (tbl_main[r]) apply(tbl_main[r], $sformatf("ready_main[%0d]", r));
        chk("drain_main", 32'(sbq.size()), 32'd0);
        foreach (tbl_pre[r]) apply(tbl_pre[r], $sformatf("ready_pre[%0d]", r));

        // Reset with three ops in flight: all discarded, nothing returned
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        sbq.delete();
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        chk("midrst_mul_b", 32'(mul_b), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_rsp_p", 32'(bus.rsp_p), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("midrst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.req_valid = 4'b0000;
        @(negedge clk) rst_n = 1'b1;
        foreach (tbl_post[r]) apply(tbl_post[r], $sformatf("ready_post[%0d]", r));
        chk("drain_post", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
